alarm_ctrl: RTL and testbench

- Clocked, parametrised alarm controller for a perimeter of NUM_DOORS doors and NUM_WINDOWS windows.
- Supports away and stay arming modes, with exit and entry delay timers.
- A tripped alarm stays latched until an explicit disarm.
- Sits between sensor inputs (already synchronised to clk) and the siren/indicator drivers.

---
 rtl/alarm_pkg.sv | 36 +++
 rtl/alarm_ctrl_if.sv | 46 ++++
 rtl/alarm_timer.sv | 38 +++
 rtl/alarm_ctrl.sv | 171 +++++++++++++++++
 tb/tb_alarm_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_pkg
//  Description : Shared types for the alarm controller: FSM state codes,
//                arming-mode encoding and the countdown-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package alarm_pkg;

    // Externally visible state codes; 6 and 7 are illegal
    typedef enum logic [2:0] {
        DISARMED   = 3'd0,
        EXIT       = 3'd1,
        ARMED_AWAY = 3'd2,
        ARMED_STAY = 3'd3,
        ENTRY      = 3'd4,
        ALARM      = 3'd5
    } state_e;

    // Which arming request was accepted
    typedef enum logic {
        MODE_AWAY = 1'b0,
        MODE_STAY = 1'b1
    } mode_e;

    localparam int STATE_W = 3;

    // Countdown width: enough bits to hold the longer of the two delays
    function automatic int cnt_width(input int exit_d, input int entry_d);
        int m;
        m = (exit_d > entry_d) ? exit_d : entry_d;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage : alarm_pkg
`default_nettype wire

// File: rtl/alarm_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_ctrl_if
//  Description : Sensor/request and indicator bundle of the alarm controller.
//                slave = controller side, master = driver/observer side.
//                tripped_zones exists only when ALARM_ZONE_LATCH_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface alarm_ctrl_if #(
    parameter int NUM_DOORS   = 2,
    parameter int NUM_WINDOWS = 3,
    parameter int CNT_W       = 4
);
    logic                   arm_away;
    logic                   arm_stay;
    logic                   disarm;
    logic [NUM_DOORS-1:0]   doors;
    logic [NUM_WINDOWS-1:0] windows;
    logic                   secure;
    logic                   armed;
    logic                   alarm;
    logic [2:0]             state;
    logic [CNT_W-1:0]       countdown;
`ifdef ALARM_ZONE_LATCH_EN
    logic [NUM_DOORS+NUM_WINDOWS-1:0] tripped_zones;

    modport slave (
        input  arm_away, arm_stay, disarm, doors, windows,
        output secure, armed, alarm, state, countdown, tripped_zones
    );
    modport master (
        output arm_away, arm_stay, disarm, doors, windows,
        input  secure, armed, alarm, state, countdown, tripped_zones
    );
`else
    modport slave (
        input  arm_away, arm_stay, disarm, doors, windows,
        output secure, armed, alarm, state, countdown
    );
    modport master (
        output arm_away, arm_stay, disarm, doors, windows,
        input  secure, armed, alarm, state, countdown
    );
`endif
endinterface : alarm_ctrl_if
`default_nettype wire

// File: rtl/alarm_timer.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_timer
//  Description : Loadable down-counter shared by the exit and entry delays.
//                Saturates at zero; done flags the last cycle of a delay
//                (count 1) or an empty delay (count 0).
//  Revision    : 1.0  initial release
// ============================================================================
module alarm_timer #(
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] load_val,
    input  wire logic             en,
    output logic      [CNT_W-1:0] count,
    output logic                  done
);

    logic [CNT_W-1:0] r_count;

    // Load has priority; otherwise count down without wrapping below zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign done  = (r_count == '0) || (r_count == CNT_W'(1));

endmodule : alarm_timer
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_ctrl
//  Description : Perimeter alarm controller with away/stay arming, exit and
//                entry delays and a latched siren output.
//                Optional macro ALARM_ZONE_LATCH_EN adds the sticky
//                tripped_zones record ({windows, doors}).
//  Revision    : 1.0  initial release
// ============================================================================
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int NUM_DOORS   = 2,
    parameter int NUM_WINDOWS = 3,
    parameter int EXIT_DELAY  = 8,
    parameter int ENTRY_DELAY = 8
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    alarm_ctrl_if.slave    bus
);

    localparam int CNT_W = cnt_width(EXIT_DELAY, ENTRY_DELAY);
    localparam logic [CNT_W-1:0] c_exit_load  = CNT_W'(EXIT_DELAY);
    localparam logic [CNT_W-1:0] c_entry_load = CNT_W'(ENTRY_DELAY);

    state_e           r_state;
    state_e           w_next;
    logic             r_secure;
    logic             r_alarm;
    logic             w_all_closed;
    logic             w_win_open;
    logic             w_door_open;
    logic             w_arm_one;
    mode_e            w_mode;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_en;
    logic [CNT_W-1:0] w_tmr_count;
    logic             w_tmr_done;

    assign w_win_open   = |bus.windows;
    assign w_door_open  = |bus.doors;
    assign w_all_closed = !w_win_open && !w_door_open;
    // Simultaneous away+stay is ambiguous and therefore ignored
    assign w_arm_one    = bus.arm_away ^ bus.arm_stay;
    assign w_mode       = bus.arm_away ? MODE_AWAY : MODE_STAY;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DISARMED;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decision; disarm overrides everything else
    always_comb begin
        w_next = r_state;
        if (bus.disarm) begin
            w_next = DISARMED;
        end else begin
            case (r_state)
                DISARMED: begin
                    if (w_arm_one && w_all_closed) begin
                        w_next = (w_mode == MODE_AWAY) ? EXIT : ARMED_STAY;
                    end
                end
                EXIT: begin
                    // Sensors are ignored while the occupant leaves
                    if (w_tmr_done) begin
                        w_next = ARMED_AWAY;
                    end
                end
                ARMED_AWAY: begin
                    if (w_win_open) begin
                        w_next = ALARM;
                    end else if (w_door_open) begin
                        w_next = ENTRY;
                    end
                end
                ARMED_STAY: begin
                    if (!w_all_closed) begin
                        w_next = ALARM;
                    end
                end
                ENTRY: begin
                    // Closing the door again does not cancel the entry delay
                    if (w_win_open || w_tmr_done) begin
                        w_next = ALARM;
                    end
                end
                ALARM: begin
                    w_next = ALARM;
                end
                default: begin
                    w_next = DISARMED;
                end
            endcase
        end
    end

    // Timer control: load on any state change (delay value or zero), else count
    always_comb begin
        w_tmr_load = (w_next != r_state);
        w_tmr_en   = !w_tmr_load;
        w_tmr_val  = '0;
        if (w_next == EXIT) begin
            w_tmr_val = c_exit_load;
        end else if (w_next == ENTRY) begin
            w_tmr_val = c_entry_load;
        end
    end

    alarm_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .en       (w_tmr_en),
        .count    (w_tmr_count),
        .done     (w_tmr_done)
    );

    // Registered indicators: secure lags the sensors by one cycle, alarm
    // rises together with the ALARM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_secure <= 1'b0;
            r_alarm  <= 1'b0;
        end else begin
            r_secure <= w_all_closed;
            r_alarm  <= (w_next == ALARM);
        end
    end

`ifdef ALARM_ZONE_LATCH_EN
    logic [NUM_DOORS+NUM_WINDOWS-1:0] r_zones;
    logic                             w_accept;
    logic                             w_capture;

    assign w_accept  = (r_state == DISARMED) && !bus.disarm && w_arm_one && w_all_closed;
    assign w_capture = ((w_next == ENTRY) && (r_state != ENTRY)) ||
                       (w_next == ALARM) || (r_state == ALARM);

    // Sticky record of open zones; survives disarm, cleared on a new arm
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zones <= '0;
        end else if (w_accept) begin
            r_zones <= '0;
        end else if (w_capture) begin
            r_zones <= r_zones | {bus.windows, bus.doors};
        end
    end

    assign bus.tripped_zones = r_zones;
`endif

    assign bus.state     = r_state;
    assign bus.armed     = (r_state == ARMED_AWAY) || (r_state == ARMED_STAY) ||
                           (r_state == ENTRY);
    assign bus.alarm     = r_alarm;
    assign bus.secure    = r_secure;
    assign bus.countdown = w_tmr_count;

endmodule : alarm_ctrl
`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_ctrl
//  Description : Self-checking bench for alarm_ctrl: directed scenarios plus
//                randomized traffic against a deadline-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alarm_ctrl;

    localparam int ND      = 2;
    localparam int NW      = 3;
    localparam int EXIT_D  = 8;
    localparam int ENTRY_D = 8;
    localparam int CW      = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alarm_ctrl_if #(.NUM_DOORS(ND), .NUM_WINDOWS(NW), .CNT_W(CW)) bus ();

    alarm_ctrl #(
        .NUM_DOORS   (ND),
        .NUM_WINDOWS (NW),
        .EXIT_DELAY  (EXIT_D),
        .ENTRY_DELAY (ENTRY_D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: state code, absolute deadline cycle of the running delay
    int cyc;
    int m_state;
    int m_deadline;
    bit m_alarm;
    bit m_secure;
`ifdef ALARM_ZONE_LATCH_EN
    logic [ND+NW-1:0] m_zones;
`endif

    function automatic int m_countdown();
        int r;
        if (m_state == 1 || m_state == 4) begin
            r = m_deadline - cyc;
            return (r < 0) ? 0 : r;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_alarm  = 0;
        m_secure = 0;
`ifdef ALARM_ZONE_LATCH_EN
        m_zones  = '0;
`endif
    endtask

    task automatic model_edge();
        int cd;
        int ns;
        bit closed;
        bit one;
        bit accept;
        cd     = m_countdown();
        closed = (bus.doors == 0) && (bus.windows == 0);
        one    = (bus.arm_away != bus.arm_stay);
        ns     = m_state;
        accept = 0;
        if (bus.disarm) ns = 0;
        else begin
            case (m_state)
                0: if (one && closed) begin accept = 1; ns = bus.arm_away ? 1 : 3; end
                1: if (cd <= 1) ns = 2;
                2: if (bus.windows != 0) ns = 5; else if (bus.doors != 0) ns = 4;
                3: if (!closed) ns = 5;
                4: if (bus.windows != 0 || cd <= 1) ns = 5;
                5: ns = 5;
                default: ns = 0;
            endcase
        end
`ifdef ALARM_ZONE_LATCH_EN
        if (accept) m_zones = '0;
        else if ((ns == 4 && m_state != 4) || ns == 5 || m_state == 5)
            m_zones = m_zones | {bus.windows, bus.doors};
`else
        if (accept) cd = 0;
`endif
        cyc++;
        if (ns == 1 && m_state != 1) m_deadline = cyc + EXIT_D;
        if (ns == 4 && m_state != 4) m_deadline = cyc + ENTRY_D;
        m_secure = closed;
        m_alarm  = (ns == 5);
        m_state  = ns;
    endtask

    // One clock: model follows the edge, outputs are then sampled at negedge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.arm_away = 0; bus.arm_stay = 0; bus.disarm = 0;
        bus.doors = '0; bus.windows = '0;
    endtask

    task automatic do_disarm();
        bus.disarm = 1; step(); bus.disarm = 0;
    endtask

    // Arm away and wait for ARMED_AWAY within a bounded number of cycles
    task automatic arm_away_wait();
        int k;
        bus.arm_away = 1; step(); bus.arm_away = 0;
        k = 0;
        while (bus.state !== 3'd2 && k < 20) begin step(); k++; end
        n_checks++;
        if (bus.state !== 3'd2) begin
            n_errors++;
            $display("FAIL armed_away_timeout: state %0d, wanted 2", bus.state);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.doors = 2'b01;
        rst_n = 0;
        #23;
        n_checks++; if (bus.state !== 3'd0)   begin n_errors++; $display("FAIL rst_state: got %0d want 0", bus.state); end
        n_checks++; if (bus.armed !== 1'b0)   begin n_errors++; $display("FAIL rst_armed: got %b want 0", bus.armed); end
        n_checks++; if (bus.alarm !== 1'b0)   begin n_errors++; $display("FAIL rst_alarm: got %b want 0", bus.alarm); end
        n_checks++; if (bus.countdown !== '0) begin n_errors++; $display("FAIL rst_cnt: got %0d want 0", bus.countdown); end
        n_checks++; if (bus.secure !== 1'b0)  begin n_errors++; $display("FAIL rst_secure: got %b want 0", bus.secure); end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        step();
        n_checks++; if (bus.secure !== 1'b0) begin n_errors++; $display("FAIL secure_open: got %b want 0", bus.secure); end
        bus.doors = 2'b00;
        step();
        n_checks++; if (bus.secure !== 1'b1) begin n_errors++; $display("FAIL secure_closed: got %b want 1", bus.secure); end
    endtask

    task automatic test_away_exit();
        clear_inputs();
        bus.arm_away = 1; step(); bus.arm_away = 0;
        n_checks++;
        if (bus.state !== 3'd1 || bus.countdown !== 4'd8) begin
            n_errors++; $display("FAIL exit_start: state %0d cnt %0d, want 1/8", bus.state, bus.countdown);
        end
        for (int i = 7; i >= 1; i--) begin
            step();
            n_checks++;
            if (bus.state !== 3'd1 || bus.countdown !== CW'(i)) begin
                n_errors++; $display("FAIL exit_count: state %0d cnt %0d, want 1/%0d", bus.state, bus.countdown, i);
            end
        end
        step();
        n_checks++;
        if (bus.state !== 3'd2 || bus.countdown !== '0 || bus.armed !== 1'b1) begin
            n_errors++; $display("FAIL exit_done: state %0d cnt %0d armed %b, want 2/0/1", bus.state, bus.countdown, bus.armed);
        end
        bus.windows = 3'b100; step(); bus.windows = '0;
        n_checks++;
        if (bus.state !== 3'd5 || bus.alarm !== 1'b1) begin
            n_errors++; $display("FAIL away_window: state %0d alarm %b, want 5/1", bus.state, bus.alarm);
        end
        step(); step(); step();
        n_checks++; if (bus.alarm !== 1'b1) begin n_errors++; $display("FAIL alarm_latched: got %b want 1", bus.alarm); end
        do_disarm();
        n_checks++;
        if (bus.state !== 3'd0 || bus.alarm !== 1'b0) begin
            n_errors++; $display("FAIL alarm_disarm: state %0d alarm %b, want 0/0", bus.state, bus.alarm);
        end
    endtask

    task automatic test_entry();
        clear_inputs();
        arm_away_wait();
        bus.doors = 2'b01; step(); bus.doors = '0;
        n_checks++;
        if (bus.state !== 3'd4 || bus.countdown !== 4'd8) begin
            n_errors++; $display("FAIL entry_start: state %0d cnt %0d, want 4/8", bus.state, bus.countdown);
        end
        for (int i = 0; i < 7; i++) step();
        n_checks++;
        if (bus.state !== 3'd4 || bus.alarm !== 1'b0 || bus.countdown !== 4'd1) begin
            n_errors++; $display("FAIL entry_last: state %0d alarm %b cnt %0d, want 4/0/1", bus.state, bus.alarm, bus.countdown);
        end
        step();
        n_checks++;
        if (bus.state !== 3'd5 || bus.alarm !== 1'b1) begin
            n_errors++; $display("FAIL entry_expire: state %0d alarm %b, want 5/1", bus.state, bus.alarm);
        end
        do_disarm();
        arm_away_wait();
        bus.doors = 2'b01; step(); bus.doors = '0;
        for (int i = 0; i < 5; i++) step();
        n_checks++; if (bus.countdown !== 4'd3) begin n_errors++; $display("FAIL entry_cnt3: got %0d want 3", bus.countdown); end
        do_disarm();
        n_checks++;
        if (bus.state !== 3'd0 || bus.alarm !== 1'b0 || bus.countdown !== '0) begin
            n_errors++; $display("FAIL entry_disarm: state %0d alarm %b cnt %0d, want 0/0/0", bus.state, bus.alarm, bus.countdown);
        end
    endtask

    task automatic test_stay();
        clear_inputs();
        bus.arm_stay = 1; step(); bus.arm_stay = 0;
        n_checks++;
        if (bus.state !== 3'd3 || bus.armed !== 1'b1 || bus.countdown !== '0) begin
            n_errors++; $display("FAIL stay_arm: state %0d armed %b cnt %0d, want 3/1/0", bus.state, bus.armed, bus.countdown);
        end
        bus.doors = 2'b01; bus.windows = 3'b110; step(); clear_inputs();
        n_checks++;
        if (bus.state !== 3'd5 || bus.alarm !== 1'b1) begin
            n_errors++; $display("FAIL stay_trip: state %0d alarm %b, want 5/1", bus.state, bus.alarm);
        end
        do_disarm();
    endtask

    task automatic test_rejected();
        clear_inputs();
        bus.windows = 3'b001; bus.arm_away = 1; step(); clear_inputs();
        n_checks++; if (bus.state !== 3'd0) begin n_errors++; $display("FAIL arm_open: state %0d want 0", bus.state); end
        bus.arm_away = 1; bus.arm_stay = 1; step(); clear_inputs();
        n_checks++; if (bus.state !== 3'd0) begin n_errors++; $display("FAIL arm_both: state %0d want 0", bus.state); end
        bus.arm_away = 1; step(); bus.arm_away = 0;
        step();
        bus.arm_away = 1; step(); bus.arm_away = 0;
        n_checks++;
        if (bus.countdown !== 4'd6) begin n_errors++; $display("FAIL exit_rearm: cnt %0d want 6", bus.countdown); end
        do_disarm();
        bus.arm_stay = 1; step(); bus.arm_stay = 0;
        bus.doors = 2'b10; step(); bus.doors = '0;
        bus.disarm = 1; bus.arm_away = 1; step(); clear_inputs();
        n_checks++;
        if (bus.state !== 3'd0 || bus.alarm !== 1'b0) begin
            n_errors++; $display("FAIL disarm_prio: state %0d alarm %b, want 0/0", bus.state, bus.alarm);
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        arm_away_wait();
        bus.doors = 2'b01; step(); bus.doors = '0;
        step(); step(); step();
        n_checks++; if (bus.countdown !== 4'd5) begin n_errors++; $display("FAIL mid_cnt5: got %0d want 5", bus.countdown); end
        #2 rst_n = 0;
        #1;
        n_checks++;
        if (bus.state !== 3'd0 || bus.armed !== 1'b0 || bus.alarm !== 1'b0 ||
            bus.countdown !== '0 || bus.secure !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: state %0d armed %b alarm %b cnt %0d secure %b, want all 0",
                     bus.state, bus.armed, bus.alarm, bus.countdown, bus.secure);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

`ifdef ALARM_ZONE_LATCH_EN
    task automatic test_zones();
        clear_inputs();
        arm_away_wait();
        bus.windows = 3'b010; step(); bus.windows = '0;
        n_checks++; if (bus.tripped_zones !== 5'b01000) begin n_errors++; $display("FAIL zones_trip: got %b want 01000", bus.tripped_zones); end
        do_disarm();
        n_checks++; if (bus.tripped_zones !== 5'b01000) begin n_errors++; $display("FAIL zones_keep: got %b want 01000", bus.tripped_zones); end
        bus.arm_stay = 1; step(); bus.arm_stay = 0;
        n_checks++; if (bus.tripped_zones !== 5'b00000) begin n_errors++; $display("FAIL zones_clear: got %b want 00000", bus.tripped_zones); end
        do_disarm();
    endtask
`endif

    task automatic test_random();
        clear_inputs();
        for (int n = 0; n < 600; n++) begin
            bus.disarm   = ($urandom_range(0, 11) == 0);
            bus.arm_away = ($urandom_range(0, 5) == 0);
            bus.arm_stay = ($urandom_range(0, 7) == 0);
            bus.doors    = ($urandom_range(0, 4) == 0) ? ND'($urandom) : '0;
            bus.windows  = ($urandom_range(0, 7) == 0) ? NW'($urandom) : '0;
            step();
            n_checks++;
            if (bus.state !== 3'(m_state) || bus.countdown !== CW'(m_countdown()) ||
                bus.alarm !== m_alarm || bus.secure !== m_secure ||
                bus.armed !== (m_state == 2 || m_state == 3 || m_state == 4)) begin
                n_errors++;
                $display("FAIL rand_cycle%0d: state %0d cnt %0d alarm %b secure %b armed %b, want %0d/%0d/%b/%b",
                         n, bus.state, bus.countdown, bus.alarm, bus.secure, bus.armed,
                         m_state, m_countdown(), m_alarm, m_secure);
            end
`ifdef ALARM_ZONE_LATCH_EN
            n_checks++;
            if (bus.tripped_zones !== m_zones) begin
                n_errors++; $display("FAIL rand_zones%0d: got %b want %b", n, bus.tripped_zones, m_zones);
            end
`endif
        end
        clear_inputs();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        m_deadline = 0;
        rst_n    = 0;
        clear_inputs();
        model_reset();
        test_reset();
        test_away_exit();
        test_entry();
        test_stay();
        test_rejected();
        test_reset_mid();
`ifdef ALARM_ZONE_LATCH_EN
        test_zones();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alarm_ctrl
`default_nettype wire
